// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush scheduler for the 5-stage pipeline.
// Merges hazard, cache, divider, branch and exception sources into stage controls.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 36,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic DH_LoadUse,
  input  logic I_Busy,
  input  logic D_Busy,
  input  logic EXE_IsDiv,
  input  logic EXE_BranchTaken,
  input  logic MEM_ExcValid,
  output logic PC_Wr,
  output logic ID_Wr,
  output logic EXE_Wr,
  output logic MEM_Wr,
  output logic WB_Wr,
  output logic ID_Flush,
  output logic EXE_Flush,
  output logic MEM_Flush,
  output logic WB_Flush,
  output logic PC_Redirect,
  output logic Div_Busy,
  output logic Div_Done,
  output logic Div_Abort
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DIV_WAIT,
    S_EXC_DRAIN,
    S_EXC_REDIRECT
  } state_t;

  localparam logic [CNT_W-1:0] LP_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZERO     = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_br_pend;
  logic             w_br_pend_nxt;

  logic w_any_busy;
  logic w_br_req;
  logic w_div_last;

  logic w_pc_wr, w_id_wr, w_exe_wr, w_mem_wr, w_wb_wr;
  logic w_id_fl, w_exe_fl, w_mem_fl, w_wb_fl;
  logic w_redir, w_div_busy, w_div_done, w_div_abort;

  assign w_any_busy = I_Busy | D_Busy;
  assign w_br_req   = EXE_BranchTaken | (r_br_pend & ~I_Busy);
  // Last divide cycle once the remaining count reaches one; a D-cache
  // stall on that cycle parks the count at zero until MEM can advance.
  assign w_div_last = (r_cnt <= LP_ONE);

  // Next-state and per-stage control decode from state plus inputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_br_pend_nxt = r_br_pend;
    w_pc_wr       = 1'b1;
    w_id_wr       = 1'b1;
    w_exe_wr      = 1'b1;
    w_mem_wr      = 1'b1;
    w_wb_wr       = 1'b1;
    w_id_fl       = 1'b0;
    w_exe_fl      = 1'b0;
    w_mem_fl      = 1'b0;
    w_wb_fl       = 1'b0;
    w_redir       = 1'b0;
    w_div_busy    = 1'b0;
    w_div_done    = 1'b0;
    w_div_abort   = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (MEM_ExcValid) begin
          w_pc_wr     = 1'b0;
          w_id_fl     = 1'b1;
          w_exe_fl    = 1'b1;
          w_mem_fl    = 1'b1;
          w_wb_fl     = 1'b1;
          w_state_nxt = w_any_busy ? S_EXC_DRAIN : S_EXC_REDIRECT;
        end else if (D_Busy) begin
          w_pc_wr  = 1'b0;
          w_id_wr  = 1'b0;
          w_exe_wr = 1'b0;
          w_mem_wr = 1'b0;
          w_wb_fl  = 1'b1;
        end else if (EXE_IsDiv) begin
          w_cnt_nxt   = LP_DIV_LOAD;
          w_div_busy  = 1'b1;
          w_pc_wr     = 1'b0;
          w_id_wr     = 1'b0;
          w_exe_wr    = 1'b0;
          w_mem_fl    = 1'b1;
          w_state_nxt = S_DIV_WAIT;
        end else if (I_Busy) begin
          w_pc_wr = 1'b0;
          w_id_fl = 1'b1;
          if (EXE_BranchTaken) begin
            w_br_pend_nxt = 1'b1;
          end
        end else begin
          if (DH_LoadUse) begin
            w_pc_wr  = 1'b0;
            w_id_wr  = 1'b0;
            w_exe_fl = 1'b1;
          end
          if (w_br_req) begin
            w_id_fl       = 1'b1;
            w_br_pend_nxt = 1'b0;
          end
        end
      end
      S_DIV_WAIT: begin
        if (MEM_ExcValid) begin
          w_div_abort = 1'b1;
          w_cnt_nxt   = LP_ZERO;
          w_pc_wr     = 1'b0;
          w_id_fl     = 1'b1;
          w_exe_fl    = 1'b1;
          w_mem_fl    = 1'b1;
          w_wb_fl     = 1'b1;
          w_state_nxt = w_any_busy ? S_EXC_DRAIN : S_EXC_REDIRECT;
        end else if (w_div_last && !D_Busy) begin
          // Divide leaves EXE; the whole front end advances with it
          w_div_busy  = 1'b1;
          w_div_done  = 1'b1;
          w_cnt_nxt   = LP_ZERO;
          w_state_nxt = S_RUN;
        end else begin
          w_div_busy = 1'b1;
          w_pc_wr    = 1'b0;
          w_id_wr    = 1'b0;
          w_exe_wr   = 1'b0;
          w_mem_fl   = 1'b1;
          if (D_Busy) begin
            w_mem_wr = 1'b0;
            w_wb_fl  = 1'b1;
          end
          w_cnt_nxt = (r_cnt == LP_ZERO) ? LP_ZERO : r_cnt - LP_ONE;
        end
      end
      S_EXC_DRAIN: begin
        w_pc_wr  = 1'b0;
        w_id_wr  = 1'b0;
        w_exe_wr = 1'b0;
        w_mem_wr = 1'b0;
        w_wb_wr  = 1'b0;
        w_id_fl  = 1'b1;
        w_exe_fl = 1'b1;
        w_mem_fl = 1'b1;
        w_wb_fl  = 1'b1;
        if (!w_any_busy) begin
          w_state_nxt = S_EXC_REDIRECT;
        end
      end
      S_EXC_REDIRECT: begin
        w_redir       = 1'b1;
        w_id_fl       = 1'b1;
        w_exe_fl      = 1'b1;
        w_br_pend_nxt = 1'b0;
        w_state_nxt   = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State, divide counter and pending-branch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_cnt     <= LP_ZERO;
      r_br_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_br_pend <= w_br_pend_nxt;
    end
  end

  // Reset freezes every stage register and loads bubbles, without a clock
  assign PC_Wr       = ~rst & w_pc_wr;
  assign ID_Wr       = ~rst & w_id_wr;
  assign EXE_Wr      = ~rst & w_exe_wr;
  assign MEM_Wr      = ~rst & w_mem_wr;
  assign WB_Wr       = ~rst & w_wb_wr;
  assign ID_Flush    =  rst | w_id_fl;
  assign EXE_Flush   =  rst | w_exe_fl;
  assign MEM_Flush   =  rst | w_mem_fl;
  assign WB_Flush    =  rst | w_wb_fl;
  assign PC_Redirect = ~rst & w_redir;
  assign Div_Busy    = ~rst & w_div_busy;
  assign Div_Done    = ~rst & w_div_done;
  assign Div_Abort   = ~rst & w_div_abort;

endmodule
